// File: rtl/timer_ctrl.sv
// timer_ctrl: control FSM for a two-digit BCD seconds down-counter chain (preset load, run/pause, tick prescaler, alarm).
// Build option TIMER_CTRL_ALARM_BLINK_EN: alarm blinks at the tick rate in DONE instead of holding steady.
module timer_ctrl #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic       clock,
   input  logic       clrn,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] preset_ones,
   input  logic [3:0] preset_tens,
   input  logic       zero,
   output logic [3:0] data_ones,
   output logic [3:0] data_tens,
   output logic       loadn,
   output logic       enable,
   output logic       running,
   output logic       alarm
);

   localparam int unsigned   CW        = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          start_q, stop_q;
   logic          start_p, stop_p, start_go;
   logic [3:0]    data_ones_q, data_ones_d;
   logic [3:0]    data_tens_q, data_tens_d;
   logic [CW-1:0] tick_q, tick_d;
   logic          tick_wrap;

   function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] limit);
      return (value > limit) ? limit : value;
   endfunction

   // A simultaneous stop edge always beats a start edge.
   assign start_p   = start & ~start_q;
   assign stop_p    = stop & ~stop_q;
   assign start_go  = start_p & ~stop_p;
   assign tick_wrap = (tick_q == TICK_LAST);

   assign data_ones = data_ones_q;
   assign data_tens = data_tens_q;

   // State register with edge-detect, preset and prescaler registers
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         data_ones_q <= 4'd0;
         data_tens_q <= 4'd0;
         tick_q      <= {CW{1'b0}};
      end else begin
         state_q     <= state_d;
         start_q     <= start;
         stop_q      <= stop;
         data_ones_q <= data_ones_d;
         data_tens_q <= data_tens_d;
         tick_q      <= tick_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_go) state_d = S_LOAD;
            else          state_d = S_IDLE;
         end
         S_LOAD: state_d = S_RUN;
         S_RUN: begin
            if (stop_p)    state_d = S_PAUSE;
            else if (zero) state_d = S_DONE;
            else           state_d = S_RUN;
         end
         S_PAUSE: begin
            if (stop_p)        state_d = S_IDLE;
            else if (start_go) state_d = S_RUN;
            else               state_d = S_PAUSE;
         end
         S_DONE: begin
            if (stop_p)        state_d = S_IDLE;
            else if (start_go) state_d = S_LOAD;
            else               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Preset capture (clamped to 59) and prescaler next value
   always_comb begin
      if (start_go && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
         data_ones_d = clamp_digit(preset_ones, 4'd9);
         data_tens_d = clamp_digit(preset_tens, 4'd5);
      end else begin
         data_ones_d = data_ones_q;
         data_tens_d = data_tens_q;
      end
      tick_d = {CW{1'b0}};
      case (state_q)
         S_RUN: begin
            if (state_d == S_DONE) tick_d = {CW{1'b0}};
            else if (tick_wrap)    tick_d = {CW{1'b0}};
            else                   tick_d = tick_q + CW'(1'b1);
         end
         S_PAUSE: tick_d = tick_q;
`ifdef TIMER_CTRL_ALARM_BLINK_EN
         S_DONE: begin
            if (state_d != S_DONE) tick_d = {CW{1'b0}};
            else if (tick_wrap)    tick_d = {CW{1'b0}};
            else                   tick_d = tick_q + CW'(1'b1);
         end
`endif
         default: tick_d = {CW{1'b0}};
      endcase
   end

`ifdef TIMER_CTRL_ALARM_BLINK_EN
   logic alarm_q, alarm_d;

   // Alarm phase: set on entry to DONE, flips on every prescaler wrap while there
   always_comb begin
      alarm_d = 1'b0;
      if (state_d != S_DONE)      alarm_d = 1'b0;
      else if (state_q != S_DONE) alarm_d = 1'b1;
      else if (tick_wrap)         alarm_d = ~alarm_q;
      else                        alarm_d = alarm_q;
   end

   // Alarm phase register
   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) alarm_q <= 1'b0;
      else       alarm_q <= alarm_d;
   end
`endif

   // Output decode from state and prescaler
   always_comb begin
      loadn   = (state_q != S_LOAD);
      running = (state_q == S_RUN);
      enable  = (state_q == S_RUN) && tick_wrap && !zero;
`ifdef TIMER_CTRL_ALARM_BLINK_EN
      alarm   = alarm_q;
`else
      alarm   = (state_q == S_DONE);
`endif
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural BCD chain and a cycle-level reference model.
module tb_timer_ctrl;

   localparam int TD = 4;
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

   logic       clock = 1'b0;
   logic       clrn  = 1'b1;
   logic       start = 1'b0;
   logic       stop  = 1'b0;
   logic [3:0] preset_ones = 4'd0;
   logic [3:0] preset_tens = 4'd0;
   logic       zero;
   logic [3:0] data_ones, data_tens;
   logic       loadn, enable, running, alarm;

   int checks = 0;
   int errors = 0;
   int chain_val = 0;
   int en_count = 0;
   int lo_count = 0;

   timer_ctrl #(.TICK_DIV(TD)) dut (
      .clock(clock), .clrn(clrn), .start(start), .stop(stop),
      .preset_ones(preset_ones), .preset_tens(preset_tens), .zero(zero),
      .data_ones(data_ones), .data_tens(data_tens), .loadn(loadn),
      .enable(enable), .running(running), .alarm(alarm)
   );

   always #5 clock = ~clock;

   // Behavioural two-digit BCD down-counter chain (value kept as 0..59)
   assign zero = (chain_val == 0);
   always @(posedge clock) begin
      if (!loadn) chain_val <= int'(data_tens) * 10 + int'(data_ones);
      else if (enable && chain_val > 0) chain_val <= chain_val - 1;
   end

   always @(posedge clock) if (enable) en_count <= en_count + 1;
   always @(negedge clock) if (!loadn) lo_count++;

   always @(posedge enable) begin
      if (!clrn) begin
         checks++;
         errors++;
         $display("FAIL enable_in_reset enable rose while clrn low at %0t", $time);
      end
   end

   // Reference model: mode plus elapsed-cycle counts since load / since DONE entry
   int   m_mode = M_IDLE;
   int   m_run  = 0;
   int   m_done = 0;
   int   m_ones = 0;
   int   m_tens = 0;
   logic m_pstart = 1'b0, m_pstop = 1'b0, m_sp, m_tp;

   always @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         m_mode = M_IDLE; m_run = 0; m_done = 0; m_ones = 0; m_tens = 0;
         m_pstart = 1'b0; m_pstop = 1'b0;
      end else begin
         m_sp = start && !m_pstart;
         m_tp = stop && !m_pstop;
         m_pstart = start;
         m_pstop  = stop;
         case (m_mode)
            M_IDLE: if (!m_tp && m_sp) begin
               m_mode = M_LOAD;
               m_ones = (preset_ones > 9) ? 9 : int'(preset_ones);
               m_tens = (preset_tens > 5) ? 5 : int'(preset_tens);
            end
            M_LOAD: begin m_mode = M_RUN; m_run = 0; end
            M_RUN: begin
               m_run++;
               if (m_tp) m_mode = M_PAUSE;
               else if (chain_val == 0) begin m_mode = M_DONE; m_done = 0; end
            end
            M_PAUSE: begin
               if (m_tp) m_mode = M_IDLE;
               else if (m_sp) m_mode = M_RUN;
            end
            M_DONE: begin
               m_done++;
               if (m_tp) m_mode = M_IDLE;
               else if (m_sp) begin
                  m_mode = M_LOAD;
                  m_ones = (preset_ones > 9) ? 9 : int'(preset_ones);
                  m_tens = (preset_tens > 5) ? 5 : int'(preset_tens);
               end
            end
            default: m_mode = M_IDLE;
         endcase
      end
   end

   logic [11:0] dut_v, exp_v;
   logic        exp_alarm;

   // Every-cycle comparison of all outputs against the model
   always @(negedge clock) begin
`ifdef TIMER_CTRL_ALARM_BLINK_EN
      exp_alarm = (m_mode == M_DONE) && (((m_done / TD) % 2) == 0);
`else
      exp_alarm = (m_mode == M_DONE);
`endif
      exp_v = {4'(m_ones), 4'(m_tens), (m_mode != M_LOAD),
               (m_mode == M_RUN) && ((m_run % TD) == TD - 1) && (chain_val != 0),
               (m_mode == M_RUN), exp_alarm};
      dut_v = {data_ones, data_tens, loadn, enable, running, alarm};
      checks++;
      if (dut_v !== exp_v) begin
         errors++;
         $display("FAIL model_cmp t=%0t {ones,tens,loadn,en,run,alarm} dut=%b exp=%b", $time, dut_v, exp_v);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse(input logic s, input logic p);
      start = s; stop = p;
      @(negedge clock);
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic wait_alarm(input int budget, output int n);
      n = 0;
      while (alarm !== 1'b1 && n < budget) begin @(negedge clock); n++; end
      check("wait_alarm_timeout", int'(alarm === 1'b1), 1);
   endtask

   task automatic wait_en(input int target, input int budget, output int n);
      n = 0;
      while (en_count < target && n < budget) begin @(negedge clock); n++; end
      check("wait_enable_timeout", int'(en_count >= target), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, e0, l0;
      // 1. reset with random inputs
      #1 clrn = 1'b0;
      repeat (3) begin
         @(negedge clock);
         start = 1'($urandom_range(1, 0));
         stop  = 1'($urandom_range(1, 0));
         preset_ones = 4'($urandom_range(15, 0));
         preset_tens = 4'($urandom_range(15, 0));
         check("rst_loadn", int'(loadn), 1);
      end
      @(negedge clock);
      check("rst_outputs", int'({data_ones, data_tens, loadn, enable, running, alarm}), 12'h008);
      start = 1'b0; stop = 1'b0; preset_ones = 4'd0; preset_tens = 4'd0;
      clrn = 1'b1;
      cyc(2);

      // 2. basic countdown 02
      preset_tens = 4'd0; preset_ones = 4'd2;
      e0 = en_count; l0 = lo_count;
      pulse(1'b1, 1'b0);
      wait_alarm(100, n);
      check("s2_start_to_alarm", n, 10);
      check("s2_pulses", en_count - e0, 2);
      check("s2_loadn_cycles", lo_count - l0, 1);
      check("s2_chain_end", chain_val, 0);
      cyc(4);
`ifdef TIMER_CTRL_ALARM_BLINK_EN
      check("s2_alarm_phase2", int'(alarm), 0);
      cyc(4);
      check("s2_alarm_phase3", int'(alarm), 1);
`else
      check("s2_alarm_steady", int'(alarm), 1);
`endif

      // 3. pause/resume with preset 15
      preset_tens = 4'd1; preset_ones = 4'd5;
      e0 = en_count;
      pulse(1'b1, 1'b0);
      wait_en(e0 + 6, 200, n);
      check("s3_chain_at_stop", chain_val, 9);
      pulse(1'b0, 1'b1);
      check("s3_paused_running", int'(running), 0);
      cyc(20);
      check("s3_hold_chain", chain_val, 9);
      check("s3_hold_pulses", en_count - e0, 6);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_en(e0 + 7, 50, n);
      check("s3_resume_partial", n, 3);
      wait_alarm(200, n);
      check("s3_total_pulses", en_count - e0, 15);
      check("s3_chain_end", chain_val, 0);

      // 4. clamp then zero preset
      preset_ones = 4'd12; preset_tens = 4'd7;
      pulse(1'b1, 1'b0);
      check("s4_clamp_ones", int'(data_ones), 9);
      check("s4_clamp_tens", int'(data_tens), 5);
      check("s4_loadn_low", int'(loadn), 0);
      cyc(1);
      check("s4_chain_59", chain_val, 59);
      pulse(1'b0, 1'b1);
      cyc(1);
      pulse(1'b0, 1'b1);
      check("s4_idle_running", int'(running), 0);
      preset_ones = 4'd0; preset_tens = 4'd0;
      e0 = en_count;
      pulse(1'b1, 1'b0);
      wait_alarm(20, n);
      check("s4_zero_to_done", n, 2);
      check("s4_zero_pulses", en_count - e0, 0);

      // 5. simultaneous events and DONE exits
      preset_ones = 4'd5; preset_tens = 4'd0;
      pulse(1'b1, 1'b0);
      cyc(3);
      pulse(1'b1, 1'b1);
      check("s5_both_gives_pause", int'(running), 0);
      check("s5_pause_loadn", int'(loadn), 1);
      cyc(1);
      pulse(1'b1, 1'b0);
      check("s5_resume_running", int'(running), 1);
      wait_alarm(200, n);
      cyc(1);
      pulse(1'b1, 1'b0);
      check("s5_done_start_load", int'(loadn), 0);
      check("s5_done_start_alarm", int'(alarm), 0);
      wait_alarm(200, n);
      cyc(1);
      pulse(1'b0, 1'b1);
      check("s5_done_stop_alarm", int'(alarm), 0);
      check("s5_done_stop_running", int'(running), 0);
      cyc(1);
      pulse(1'b1, 1'b1);
      cyc(1);
      check("s5_idle_both_loadn", int'(loadn), 1);
      check("s5_idle_both_running", int'(running), 0);

      // 6. asynchronous reset mid-run at 07
      preset_ones = 4'd0; preset_tens = 4'd1;
      e0 = en_count;
      pulse(1'b1, 1'b0);
      wait_en(e0 + 3, 100, n);
      check("s6_chain_07", chain_val, 7);
      check("s6_running_before", int'(running), 1);
      #2 clrn = 1'b0;
      #1;
      check("s6_async_outputs", int'({data_ones, data_tens, loadn, enable, running, alarm}), 12'h008);
      cyc(2);
      clrn = 1'b1;
      cyc(2);
      check("s6_idle_after", int'(running), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
